// File: rtl/inst_ram_loader.sv
// inst_ram_loader: touchscreen-driven writer for a synchronous single-port
// instruction RAM. Takes an address then a data word, writes it, reads it
// back, compares, and keeps write/error counters plus a display readout.
// Optional build macro: INST_RAM_LOADER_AUTO_INC_EN (streaming writes with
// automatic address increment and in-place address reload via cmd_addr).
module inst_ram_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              input_valid,
  input  logic [31:0]       input_value,
  input  logic              cmd_addr,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy,
  output logic              err_flag,
  input  logic [5:0]        display_number,
  output logic              display_valid,
  output logic [39:0]       display_name,
  output logic [31:0]       display_value
);

  localparam logic [2:0] S_ADDR  = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        display_valid_q, display_valid_d;
  logic [39:0] display_name_q, display_name_d;
  logic [31:0] display_value_q, display_value_d;

`ifndef INST_RAM_LOADER_AUTO_INC_EN
  // cmd_addr only matters in streaming builds.
  logic cmd_addr_unused;
  assign cmd_addr_unused = cmd_addr;
`endif

  // RAM-side signals are straight decodes of the registered state.
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_wdata = wdata_q;
  assign ram_wen   = (state_q == S_WRITE);
  assign busy      = (state_q == S_WRITE) || (state_q == S_READ) ||
                     (state_q == S_CHECK);
  assign err_flag      = err_flag_q;
  assign display_valid = display_valid_q;
  assign display_name  = display_name_q;
  assign display_value = display_value_q;

  // Sequencer: address/data entry, write, readback and compare.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wr_cnt_d   = wr_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    case (state_q)
      S_ADDR: begin
        if (input_valid) begin
          addr_d  = {input_value[31:2], 2'b00};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (input_valid) begin
`ifdef INST_RAM_LOADER_AUTO_INC_EN
          if (cmd_addr) begin
            addr_d = {input_value[31:2], 2'b00};
          end else begin
            wdata_d = input_value;
            state_d = S_WRITE;
          end
`else
          wdata_d = input_value;
          state_d = S_WRITE;
`endif
        end
      end
      S_WRITE: state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        rdata_d  = ram_rdata;
        wr_cnt_d = wr_cnt_q + 32'd1;
        if (ram_rdata != wdata_q) begin
          err_flag_d = 1'b1;
          if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
        end
`ifdef INST_RAM_LOADER_AUTO_INC_EN
        addr_d  = addr_q + 32'd4;
        state_d = S_DATA;
`else
        state_d = S_ADDR;
`endif
      end
      default: state_d = S_ADDR;
    endcase
  end

  // Display slot decode; registered so the lcd sees a one-cycle latency.
  always_comb begin
    display_valid_d = 1'b1;
    display_name_d  = 40'd0;
    display_value_d = 32'd0;
    case (display_number)
      6'd1: begin display_name_d = "ADDR "; display_value_d = addr_q;    end
      6'd2: begin display_name_d = "WDATA"; display_value_d = wdata_q;   end
      6'd3: begin display_name_d = "RDATA"; display_value_d = rdata_q;   end
      6'd4: begin display_name_d = "WRCNT"; display_value_d = wr_cnt_q;  end
      6'd5: begin display_name_d = "ERCNT"; display_value_d = err_cnt_q; end
      6'd6: begin display_name_d = "STATE"; display_value_d = {29'd0, state_q}; end
      default: display_valid_d = 1'b0;
    endcase
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_ADDR;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      rdata_q         <= 32'd0;
      wr_cnt_q        <= 32'd0;
      err_cnt_q       <= 32'd0;
      err_flag_q      <= 1'b0;
      display_valid_q <= 1'b0;
      display_name_q  <= 40'd0;
      display_value_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      wr_cnt_q        <= wr_cnt_d;
      err_cnt_q       <= err_cnt_d;
      err_flag_q      <= err_flag_d;
      display_valid_q <= display_valid_d;
      display_name_q  <= display_name_d;
      display_value_q <= display_value_d;
    end
  end

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed testbench for inst_ram_loader with a behavioural synchronous RAM.
module tb_inst_ram_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              input_valid = 1'b0;
  logic [31:0]       input_value = 32'd0;
  logic              cmd_addr = 1'b0;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              busy;
  logic              err_flag;
  logic [5:0]        display_number = 6'd0;
  logic              display_valid;
  logic [39:0]       display_name;
  logic [31:0]       display_value;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] corrupt = 32'd0;

  int n_assert = 0;
  int n_fail = 0;

  inst_ram_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .input_valid(input_valid),
    .input_value(input_value), .cmd_addr(cmd_addr), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .err_flag(err_flag), .display_number(display_number),
    .display_valid(display_valid), .display_name(display_name),
    .display_value(display_value)
  );

  always #50 clk = ~clk;

  // Synchronous single-port RAM, read-first, optional readback corruption.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr] ^ corrupt;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] v, input logic c);
    input_valid = 1'b1;
    input_value = v;
    cmd_addr    = c;
    step();
    input_valid = 1'b0;
    cmd_addr    = 1'b0;
  endtask

  task automatic disp(input logic [5:0] n, input logic [39:0] name, input logic [31:0] val);
    display_number = n;
    step();
    chk("disp_valid", {63'd0, display_valid}, {63'd0, 1'b1});
    chk("disp_name", {24'd0, display_name}, {24'd0, name});
    chk("disp_value", {32'd0, display_value}, {32'd0, val});
  endtask

  initial begin
    resetn = 1'b0;
    step();
    step();
    chk("rst_wen", {63'd0, ram_wen}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err_flag", {63'd0, err_flag}, 64'd0);
    chk("rst_disp_valid", {63'd0, display_valid}, 64'd0);
    chk("rst_disp_value", {32'd0, display_value}, 64'd0);
    resetn = 1'b1;
    step();

`ifdef INST_RAM_LOADER_AUTO_INC_EN
    pulse(32'h0000_03FC, 1'b0);
    pulse(32'hAAAA_0001, 1'b0);
    chk("ai_wen1", {63'd0, ram_wen}, 64'd1);
    chk("ai_addr1", {56'd0, ram_addr}, 64'hFF);
    step(); step(); step();
    disp(6, "STATE", 32'd1);
    chk("ai_ram_addr_wrap", {56'd0, ram_addr}, 64'h00);
    disp(1, "ADDR ", 32'h400);
    pulse(32'hBBBB_0002, 1'b0);
    chk("ai_wen2", {63'd0, ram_wen}, 64'd1);
    chk("ai_addr2", {56'd0, ram_addr}, 64'h00);
    step(); step(); step();
    pulse(32'h0000_0020, 1'b1);
    chk("ai_cmd_no_wen", {63'd0, ram_wen}, 64'd0);
    chk("ai_cmd_ram_addr", {56'd0, ram_addr}, 64'h08);
    disp(6, "STATE", 32'd1);
    disp(1, "ADDR ", 32'h20);
    disp(4, "WRCNT", 32'd2);
    chk("ai_mem_ff", {32'd0, mem[8'hFF]}, {32'd0, 32'hAAAA_0001});
    chk("ai_mem_00", {32'd0, mem[8'h00]}, {32'd0, 32'hBBBB_0002});
`else
    // Basic write and verify
    pulse(32'h0000_0010, 1'b0);
    chk("w1_busy_data", {63'd0, busy}, 64'd0);
    pulse(32'h1234_5678, 1'b0);
    chk("w1_wen", {63'd0, ram_wen}, 64'd1);
    chk("w1_ram_addr", {56'd0, ram_addr}, 64'h04);
    chk("w1_wdata", {32'd0, ram_wdata}, 64'h1234_5678);
    chk("w1_busy", {63'd0, busy}, 64'd1);
    step();
    chk("w1_read_wen", {63'd0, ram_wen}, 64'd0);
    chk("w1_read_addr", {56'd0, ram_addr}, 64'h04);
    chk("w1_read_busy", {63'd0, busy}, 64'd1);
    step();
    chk("w1_check_busy", {63'd0, busy}, 64'd1);
    step();
    chk("w1_idle_busy", {63'd0, busy}, 64'd0);
    chk("w1_err_flag", {63'd0, err_flag}, 64'd0);
    disp(4, "WRCNT", 32'd1);
    disp(5, "ERCNT", 32'd0);
    disp(3, "RDATA", 32'h1234_5678);
    disp(2, "WDATA", 32'h1234_5678);
    disp(6, "STATE", 32'd0);

    // Misaligned address and aliasing above the RAM width
    pulse(32'h0000_0013, 1'b0);
    chk("mis_ram_addr", {56'd0, ram_addr}, 64'h04);
    disp(1, "ADDR ", 32'h10);
    disp(6, "STATE", 32'd1);
    pulse(32'hCAFE_F00D, 1'b0);
    step(); step(); step();
    pulse(32'h0000_0410, 1'b0);
    chk("alias_ram_addr", {56'd0, ram_addr}, 64'h04);
    disp(1, "ADDR ", 32'h410);
    pulse(32'h0BAD_BEEF, 1'b0);
    chk("alias_wen", {63'd0, ram_wen}, 64'd1);
    step(); step(); step();
    chk("alias_mem", {32'd0, mem[4]}, 64'h0BAD_BEEF);
    disp(4, "WRCNT", 32'd3);

    // Input pulses while busy are dropped
    pulse(32'h0000_0020, 1'b0);
    pulse(32'h55AA_55AA, 1'b0);
    input_valid = 1'b1;
    input_value = 32'hFFFF_FFF0;
    step(); step(); step();
    input_valid = 1'b0;
    chk("busy_drop_idle", {63'd0, busy}, 64'd0);
    disp(6, "STATE", 32'd0);
    disp(1, "ADDR ", 32'h20);
    disp(4, "WRCNT", 32'd4);
    disp(2, "WDATA", 32'h55AA_55AA);

    // Readback mismatch, then a clean write keeps the sticky flag
    corrupt = 32'h1;
    pulse(32'h0000_0030, 1'b0);
    pulse(32'h1111_1111, 1'b0);
    step(); step(); step();
    corrupt = 32'h0;
    chk("mm_err_flag", {63'd0, err_flag}, 64'd1);
    disp(5, "ERCNT", 32'd1);
    disp(3, "RDATA", 32'h1111_1110);
    pulse(32'h0000_0040, 1'b0);
    pulse(32'h2222_2222, 1'b0);
    step(); step(); step();
    chk("mm_sticky", {63'd0, err_flag}, 64'd1);
    disp(5, "ERCNT", 32'd1);
    disp(4, "WRCNT", 32'd6);

    // Unpopulated display slot
    display_number = 6'd7;
    step();
    chk("disp7_valid", {63'd0, display_valid}, 64'd0);
    chk("disp7_name", {24'd0, display_name}, 64'd0);
    chk("disp7_value", {32'd0, display_value}, 64'd0);

    // Reset during the write cycle
    pulse(32'h0000_0050, 1'b0);
    pulse(32'h3333_3333, 1'b0);
    chk("mid_wen_before", {63'd0, ram_wen}, 64'd1);
    resetn = 1'b0;
    step();
    chk("mid_wen_after", {63'd0, ram_wen}, 64'd0);
    chk("mid_busy", {63'd0, busy}, 64'd0);
    chk("mid_err_flag", {63'd0, err_flag}, 64'd0);
    resetn = 1'b1;
    disp(6, "STATE", 32'd0);
    disp(4, "WRCNT", 32'd0);
    disp(5, "ERCNT", 32'd0);
    disp(1, "ADDR ", 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
